// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational 8-bit ALU between NUM_REQ requesters.
// One operation in flight; divide-by-zero is answered locally and never waits on the ALU.
module alu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int EXEC_CYCLES = 1,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [4*NUM_REQ-1:0] req_sel,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [3:0]           alu_sel,
  input  logic [15:0]          alu_out,
  input  logic                 alu_carry,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_data,
  output logic                 rsp_carry,
  output logic                 rsp_err,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);
  localparam logic [3:0] SEL_DIV  = 4'b0011;
  localparam logic [3:0] CNT_LAST = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;

  logic [NUM_REQ-1:0][7:0] a_lane, b_lane;
  logic [NUM_REQ-1:0][3:0] sel_lane;
  logic [ID_W-1:0]         rr_ptr, grant, cand;
  logic                    any_vld, div0;
  logic [3:0]              cnt;

  assign a_lane   = req_a;
  assign b_lane   = req_b;
  assign sel_lane = req_sel;

  // Walk offsets high to low so the nearest valid requester after rr_ptr wins.
  always_comb begin
    grant   = '0;
    cand    = '0;
    any_vld = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant   = cand;
        any_vld = 1'b1;
      end
    end
  end

  assign div0 = (sel_lane[grant] == SEL_DIV) && (b_lane[grant] == 8'h00);

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_vld) req_ready[grant] = 1'b1;
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_vld) state_nxt = div0 ? RESP : EXEC;
      EXEC:    if (cnt == CNT_LAST) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= '0;
      cnt       <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: if (any_vld) begin
          alu_a   <= a_lane[grant];
          alu_b   <= b_lane[grant];
          alu_sel <= sel_lane[grant];
          rsp_id  <= grant;
          rr_ptr  <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + 1'b1;
          cnt     <= '0;
          if (div0) begin
            rsp_data  <= 16'hFFFF;
            rsp_carry <= 1'b0;
            rsp_err   <= 1'b1;
          end
        end
        EXEC: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            rsp_data  <= alu_out;
            rsp_carry <= alu_carry;
            rsp_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked against a
// behavioural model of round-robin order, ALU results and the divide-by-zero trap.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int N    = 4;
  localparam int EXEC = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0]        req_ready;
  logic [N-1:0][7:0]   a_arr = '0, b_arr = '0;
  logic [N-1:0][3:0]   s_arr = '0;
  logic [7:0]          alu_a, alu_b;
  logic [3:0]          alu_sel;
  logic [15:0]         alu_out;
  logic                alu_carry;
  logic                rsp_valid, rsp_carry, rsp_err, busy;
  logic                rsp_ready = 1'b1;
  logic [15:0]         rsp_data;
  logic [IDW-1:0]      rsp_id;
  int checks = 0, failures = 0, mptr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(N), .EXEC_CYCLES(EXEC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(a_arr), .req_b(b_arr), .req_sel(s_arr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_carry(rsp_carry), .rsp_err(rsp_err), .rsp_id(rsp_id), .busy(busy)
  );

  // Stand-in ALU: {carry, result}
  function automatic logic [16:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    int unsigned x, y;
    x = a; y = b;
    case (s)
      4'b0000: return {(x + y) > 255, 16'(x + y)};
      4'b0001: return {x < y, 16'((x - y) & 255)};
      4'b0010: return {1'b0, 16'(x * y)};
      4'b0011: return {1'b0, (y == 0) ? 16'hDEAD : 16'(x / y)};
      default: return {1'b0, 16'(x ^ y)};
    endcase
  endfunction

  always_comb {alu_carry, alu_out} = alu_fn(alu_a, alu_b, alu_sel);

  // Expected response {err, carry, data}
  function automatic logic [17:0] exp_rsp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    if (s == 4'b0011 && b == 8'h00) return {1'b1, 1'b0, 16'hFFFF};
    return {1'b0, alu_fn(a, b, s)};
  endfunction

  function automatic int grant_of(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[IDW'((p + k) % N)]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
    a_arr[IDW'(i)] = a; b_arr[IDW'(i)] = b; s_arr[IDW'(i)] = s; req_valid[IDW'(i)] = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; req_valid = '0; rsp_ready = 1'b1;
    @(negedge clk); rst = 1'b0; mptr = 0;
  endtask

  // Waits through the accept edge; returns cycles until rsp_valid (-1 on timeout).
  task automatic issue_wait(input int g, input bit drop, output int lat, output bit rdy_seen);
    lat = -1; rdy_seen = 1'b0;
    @(posedge clk); #1;
    if (drop) req_valid[IDW'(g)] = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      rdy_seen |= (req_ready != '0);
      if (rsp_valid) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_id, busy} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h want=0", {req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_id, busy});
    end
    rst = 1'b0; rsp_ready = 1'b1; mptr = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      failures++; $display("FAIL idle_after_reset busy=%b ready=%b want 0/0000", busy, req_ready);
    end
  endtask

  task automatic test_single_add();
    int lat; bit rs;
    do_reset();
    set_req(0, 8'hF0, 8'h20, 4'b0000); #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL add_grant got=%b want=0001", req_ready); end
    issue_wait(0, 1'b1, lat, rs); mptr = 1;
    checks++;
    if (lat != EXEC + 1 || rs) begin failures++; $display("FAIL add_latency got=%0d rdy_seen=%b want=%0d", lat, rs, EXEC + 1); end
    checks++;
    if ({rsp_data, rsp_carry, rsp_id, rsp_err} !== {16'h0110, 1'b1, 2'd0, 1'b0}) begin
      failures++; $display("FAIL add_rsp got=%h c=%b id=%0d err=%b want=0110 c=1 id=0 err=0", rsp_data, rsp_carry, rsp_id, rsp_err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL add_release valid=%b busy=%b want 0/0", rsp_valid, busy); end
  endtask

  task automatic test_round_robin();
    int lat, g; bit rs;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 8'(i + 2), 8'd3, 4'b0010);
    for (int n = 0; n < 5; n++) begin
      g = n % N;
      #1;
      checks++;
      if (req_ready !== (4'b0001 << g)) begin failures++; $display("FAIL rr_grant n=%0d got=%b want=%b", n, req_ready, 4'b0001 << g); end
      issue_wait(g, 1'b0, lat, rs);
      checks++;
      if (lat != EXEC + 1 || rsp_id !== IDW'(g) || rsp_data !== 16'(3 * (g + 2))) begin
        failures++; $display("FAIL rr_rsp n=%0d lat=%0d id=%0d data=%h want lat=%0d id=%0d data=%h", n, lat, rsp_id, rsp_data, EXEC + 1, g, 16'(3 * (g + 2)));
      end
      @(negedge clk);
    end
    req_valid = '0;
  endtask

  task automatic test_div_zero();
    int lat; bit rs;
    do_reset();
    set_req(2, 8'h10, 8'h00, 4'b0011); #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL div0_grant got=%b want=0100", req_ready); end
    issue_wait(2, 1'b1, lat, rs);
    checks++;
    if (lat != 1) begin failures++; $display("FAIL div0_latency got=%0d want=1", lat); end
    checks++;
    if ({rsp_data, rsp_carry, rsp_err, rsp_id} !== {16'hFFFF, 1'b0, 1'b1, 2'd2}) begin
      failures++; $display("FAIL div0_rsp got=%h c=%b err=%b id=%0d want=ffff c=0 err=1 id=2", rsp_data, rsp_carry, rsp_err, rsp_id);
    end
    checks++;
    if ({alu_a, alu_b, alu_sel} !== {8'h10, 8'h00, 4'b0011}) begin
      failures++; $display("FAIL div0_alu_regs got=%h/%h/%b want=10/00/0011", alu_a, alu_b, alu_sel);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat; bit rs, bad;
    logic [19:0] snap;
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 8'h07, 8'h05, 4'b0001);
    set_req(1, 8'h09, 8'h04, 4'b0010); #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_grant0 got=%b want=0001", req_ready); end
    issue_wait(0, 1'b1, lat, rs);
    checks++;
    if (lat != EXEC + 1 || rsp_data !== 16'h0002 || rsp_carry !== 1'b0) begin
      failures++; $display("FAIL bp_rsp lat=%0d data=%h c=%b want lat=%0d data=0002 c=0", lat, rsp_data, rsp_carry, EXEC + 1);
    end
    snap = {rsp_data, rsp_carry, rsp_err, rsp_id};
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || {rsp_data, rsp_carry, rsp_err, rsp_id} !== snap || req_ready !== '0 || !busy) bad = 1'b1;
    end
    checks++;
    if (bad) begin failures++; $display("FAIL bp_stall_stable got=1 want=0"); end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_next_grant got=%b valid=%b want=0010/0", req_ready, rsp_valid); end
    issue_wait(1, 1'b1, lat, rs);
    checks++;
    if (rsp_data !== 16'd36 || rsp_id !== 2'd1) begin failures++; $display("FAIL bp_rsp1 data=%h id=%0d want=0024/1", rsp_data, rsp_id); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    int lat; bit rs;
    do_reset();
    set_req(0, 8'h33, 8'h11, 4'b0000); #1;
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk); @(negedge clk);
    checks++;
    if (busy !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_exec_busy busy=%b valid=%b want 1/0", busy, rsp_valid); end
    rst = 1'b1; #1;
    checks++;
    if ({req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_id, busy} !== '0) begin
      failures++;
      $display("FAIL reset_mid_exec got=%h want=0", {req_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_carry, rsp_err, rsp_id, busy});
    end
    @(negedge clk); rst = 1'b0; mptr = 0;
    set_req(0, 8'h05, 8'h06, 4'b0010);
    set_req(1, 8'h01, 8'h01, 4'b0000); #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL post_reset_grant got=%b want=0001", req_ready); end
    issue_wait(0, 1'b1, lat, rs);
    checks++;
    if (lat != EXEC + 1 || rsp_data !== 16'd30 || rsp_id !== 2'd0) begin
      failures++; $display("FAIL post_reset_rsp lat=%0d data=%h id=%0d want %0d/001e/0", lat, rsp_data, rsp_id, EXEC + 1);
    end
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_sparse_skip();
    int lat; bit rs;
    do_reset();
    set_req(0, 8'h02, 8'h02, 4'b0000); #1;
    issue_wait(0, 1'b1, lat, rs);
    @(negedge clk);
    set_req(3, 8'h0A, 8'h03, 4'b0011); #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL sparse_grant3 got=%b want=1000", req_ready); end
    issue_wait(3, 1'b1, lat, rs);
    checks++;
    if (lat != EXEC + 1 || rsp_data !== 16'd3 || rsp_id !== 2'd3) begin
      failures++; $display("FAIL sparse_rsp3 lat=%0d data=%h id=%0d want %0d/0003/3", lat, rsp_data, rsp_id, EXEC + 1);
    end
    @(negedge clk);
    set_req(0, 8'h04, 8'h04, 4'b0000);
    set_req(3, 8'h0A, 8'h03, 4'b0011); #1;
    checks++;
    if (req_ready !== 4'b0001) begin failures++; $display("FAIL sparse_wrap_grant got=%b want=0001", req_ready); end
    issue_wait(0, 1'b1, lat, rs);
    @(negedge clk);
    req_valid = '0;
  endtask

  task automatic test_random();
    int g, lat, stall, exp_lat;
    bit rs;
    logic [17:0] er;
    logic [7:0] ea, eb;
    logic [3:0] es;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[IDW'(i)] && $urandom_range(1, 0) == 1)
          set_req(i, 8'($urandom), ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom), 4'($urandom_range(5, 0)));
      if (req_valid == '0) set_req(int'($urandom_range(N - 1, 0)), 8'($urandom), 8'h00, 4'b0011);
      g = grant_of(req_valid, mptr);
      ea = a_arr[IDW'(g)]; eb = b_arr[IDW'(g)]; es = s_arr[IDW'(g)];
      er = exp_rsp(ea, eb, es);
      exp_lat = er[17] ? 1 : EXEC + 1;
      stall = int'($urandom_range(3, 0));
      rsp_ready = (stall == 0);
      #1;
      checks++;
      if (req_ready !== (4'b0001 << g)) begin failures++; $display("FAIL rand_grant n=%0d got=%b want=%b", n, req_ready, 4'b0001 << g); end
      issue_wait(g, 1'b1, lat, rs);
      mptr = (g + 1) % N;
      checks++;
      if (lat != exp_lat || rs) begin failures++; $display("FAIL rand_latency n=%0d got=%0d rdy_seen=%b want=%0d", n, lat, rs, exp_lat); end
      checks++;
      if ({rsp_err, rsp_carry, rsp_data} !== er || rsp_id !== IDW'(g)) begin
        failures++; $display("FAIL rand_rsp n=%0d got=%h id=%0d want=%h id=%0d", n, {rsp_err, rsp_carry, rsp_data}, rsp_id, er, g);
      end
      checks++;
      if ({alu_a, alu_b, alu_sel} !== {ea, eb, es}) begin
        failures++; $display("FAIL rand_alu_regs n=%0d got=%h want=%h", n, {alu_a, alu_b, alu_sel}, {ea, eb, es});
      end
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rand_release n=%0d got=1 want=0", n); end
    end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_div_zero();
    test_backpressure();
    test_reset_mid_exec();
    test_sparse_skip();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
